// File: rtl/rs_frame_feeder_if.sv
// rs_frame_feeder_if: symbol bus joining the UART receiver, the frame feeder and the RS encoder.
interface rs_frame_feeder_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              enc_ready;
  logic              enc_done;
  logic              ce_out;
  logic [DATA_W-1:0] enc_data;
  logic              enc_sof;
  logic              enc_eof;
  modport master (
    output rx_data, rx_valid, enc_ready, enc_done,
    input  ce_out, enc_data, enc_sof, enc_eof
  );
  modport slave (
    input  rx_data, rx_valid, enc_ready, enc_done,
    output ce_out, enc_data, enc_sof, enc_eof
  );
endinterface

// File: rtl/rs_frame_feeder.sv
// rs_frame_feeder: buffers received symbols and issues full messages to the RS encoder with gap and backpressure.
module rs_frame_feeder #(
  parameter int DATA_W    = 8,
  parameter int MSG_LEN   = 16,
  parameter int DEPTH     = 32,
  parameter int GAP       = 0,
  parameter int WAIT_DONE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  rs_frame_feeder_if.slave           bus,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MSG_LEN);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DN} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        gap_q, gap_d;
  logic              ovf_q, ovf_d, ce_q, ce_d, sof_q, sof_d, eof_q, eof_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, issue, last;
  always_comb begin
    push    = bus.rx_valid && cnt_q < CW'(DEPTH);
    issue   = state_q == SEND && gap_q == '0 && bus.enc_ready;
    last    = idx_q == IW'(MSG_LEN - 1);
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = issue ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + CW'(push) - CW'(issue);
    ovf_d   = ovf_q | (bus.rx_valid & ~push);
    ce_d    = issue;
    sof_d   = issue && idx_q == '0;
    eof_d   = issue && last;
    data_d  = issue ? mem_q[rd_q] : data_q;
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    if (state_q == IDLE && cnt_q >= CW'(MSG_LEN)) begin
      state_d = SEND;
      idx_d   = '0;
      gap_d   = '0;
    end
    // the gap counter runs down even while the encoder is stalling us
    if (state_q == SEND) begin
      gap_d = issue ? 8'(GAP) : gap_q - 8'(gap_q != '0);
      idx_d = issue ? idx_q + 1'b1 : idx_q;
      if (issue && last) state_d = WAIT_DONE != 0 ? WAIT_DN : IDLE;
    end
    if (state_q == WAIT_DN && bus.enc_done) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
      ce_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      ce_q    <= ce_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      data_q  <= data_d;
    end
  end
  // storage needs no reset: emptiness is carried by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.rx_data;
  end
  assign bus.ce_out   = ce_q;
  assign bus.enc_data = data_q;
  assign bus.enc_sof  = sof_q;
  assign bus.enc_eof  = eof_q;
  assign busy         = state_q != IDLE;
  assign overflow     = ovf_q;
  assign fifo_count   = cnt_q;
endmodule
